// File: rtl/mult_pkg.sv
// Shared definitions for the sequential 8x8 multiplier and its host-side sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: sequencer state encodings, operand/product/counter widths.
package mult_pkg;

    localparam int unsigned OPND_W  = 8;
    localparam int unsigned PROD_W  = 16;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned STATE_W = 3;

    // Encodings are externally visible on state_out, so they are fixed values,
    // not left to the tool. 3'b100, 3'b110 and 3'b111 are unused.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'b000,
        ST_LOAD = 3'b001,
        ST_WAIT = 3'b010,
        ST_HOLD = 3'b011,
        ST_ERR  = 3'b101
    } state_t;

endpackage

// File: rtl/mult_host_wdog.sv
// Watchdog for the sequencer's WAIT state: flags when TIMEOUT WAIT cycles pass without done.
// Latency: o_expired is combinational and is high during the TIMEOUT-th enabled cycle.
// Backpressure: none; the counter saturates on its last value until cleared.
// Ports: clk, reset_a (async, active-low), i_clr (restart count), i_en (count this cycle),
//        o_expired (this enabled cycle is the last one allowed).
module mult_host_wdog #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_a,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    // r_cnt holds the number of WAIT cycles already completed; the cycle in
    // which it reads LAST is the TIMEOUT-th one.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/mult_host_seq.sv
// Host-side sequencer for the sequential 8x8 multiplier: accept operands, pulse start, capture product.
// Latency: 6 cycles accept-to-out_valid with the nominal multiplier (done 5 cycles after start).
// Backpressure: result held in HOLD until out_ready; in_ready only in IDLE, so no new accept meanwhile.
// Optional feature: define MULT_HOST_TIMEOUT_EN to compile in the WAIT-state watchdog (TIMEOUT cycles).
// Ports: in_valid/in_ready/in_a/in_b operand input; mult_a/mult_b/mult_start/mult_done/mult_product
//        multiplier side; out_valid/out_ready/out_product result output; op_cnt completed ops;
//        err/err_clr error state and exit; state_out raw state encoding. Clock clk, reset reset_a.
module mult_host_seq
    import mult_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset_a,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPND_W-1:0]  in_a,
    input  logic [OPND_W-1:0]  in_b,
    output logic [OPND_W-1:0]  mult_a,
    output logic [OPND_W-1:0]  mult_b,
    output logic               mult_start,
    input  logic               mult_done,
    input  logic [PROD_W-1:0]  mult_product,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PROD_W-1:0]  out_product,
    output logic [CNT_W-1:0]   op_cnt,
    output logic               err,
    input  logic               err_clr,
    output logic [STATE_W-1:0] state_out
);

    if (TIMEOUT < 6) begin : g_timeout_range
        $error("mult_host_seq: TIMEOUT must be at least 6");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_capture;
    logic                w_wdog_expired;
    logic [OPND_W-1:0]   r_mult_a;
    logic [OPND_W-1:0]   r_mult_b;
    logic [PROD_W-1:0]   r_out_product;
    logic [CNT_W-1:0]    r_op_cnt;

`ifdef MULT_HOST_TIMEOUT_EN
    // Count restarts while in LOAD, which always precedes WAIT.
    logic w_wdog_clr;
    logic w_wdog_en;

    assign w_wdog_clr = (r_state == ST_LOAD);
    assign w_wdog_en  = (r_state == ST_WAIT);

    mult_host_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .reset_a   (reset_a),
        .i_clr     (w_wdog_clr),
        .i_en      (w_wdog_en),
        .o_expired (w_wdog_expired)
    );
`else
    assign w_wdog_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A done outside WAIT means the multiplier and the sequencer disagree about
    // who owns the operation, so it wins over every other event in that state:
    // an operand offered in the same IDLE cycle is not taken, and a result in
    // HOLD is dropped even if out_ready arrives with it.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mult_done) begin
                    w_state_nxt = ST_ERR;
                end else if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (mult_done) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // done beats a coincident watchdog expiry.
                if (mult_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else if (w_wdog_expired) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_HOLD: begin
                if (mult_done) begin
                    w_state_nxt = ST_ERR;
                end else if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (err_clr) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operands load only on accept, so they stay put on the multiplier bus for
    // the whole LOAD/WAIT span regardless of what the source does next.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            r_mult_a <= '0;
            r_mult_b <= '0;
        end else if (w_accept) begin
            r_mult_a <= in_a;
            r_mult_b <= in_b;
        end
    end

    // The product is kept after HOLD exits; only the next capture replaces it.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            r_out_product <= '0;
            r_op_cnt      <= '0;
        end else if (w_capture) begin
            r_out_product <= mult_product;
            r_op_cnt      <= r_op_cnt + 1'b1;
        end
    end

    // Handshake and status outputs come straight from the state register so
    // they are glitch-free and never depend on same-cycle inputs.
    assign in_ready    = (r_state == ST_IDLE);
    assign mult_start  = (r_state == ST_LOAD);
    assign out_valid   = (r_state == ST_HOLD);
    assign err         = (r_state == ST_ERR);
    assign state_out   = r_state;

    assign mult_a      = r_mult_a;
    assign mult_b      = r_mult_b;
    assign out_product = r_out_product;
    assign op_cnt      = r_op_cnt;

endmodule

// File: tb/tb_mult_host_seq.sv
module tb_mult_host_seq;
    import mult_pkg::*;

    localparam int TO = 15;

    logic        clk      = 1'b0;
    logic        reset_a  = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a     = 8'h00;
    logic [7:0]  in_b     = 8'h00;
    logic [7:0]  mult_a;
    logic [7:0]  mult_b;
    logic        mult_start;
    logic        mult_done;
    logic [15:0] mult_product;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_product;
    logic [7:0]  op_cnt;
    logic        err;
    logic        err_clr  = 1'b0;
    logic [2:0]  state_out;

    // Multiplier stand-in: done and product 5 cycles after a sampled start.
    logic        auto_done  = 1'b0;
    logic        force_done = 1'b0;
    logic [15:0] auto_prod  = 16'h0000;
    bit          mute       = 1'b0;
    int          cd         = 0;

    assign mult_done    = auto_done | force_done;
    assign mult_product = auto_prod;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    mult_host_seq #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset_a      (reset_a),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_start   (mult_start),
        .mult_done    (mult_done),
        .mult_product (mult_product),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_product  (out_product),
        .op_cnt       (op_cnt),
        .err          (err),
        .err_clr      (err_clr),
        .state_out    (state_out)
    );

    initial begin
        forever begin
            @(posedge clk);
            #1;
            auto_done = 1'b0;
            if (!reset_a) begin
                cd = 0;
            end else if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) begin
                    auto_done = 1'b1;
                    auto_prod = 16'(mult_a) * 16'(mult_b);
                end
            end else if (mult_start && !mute) begin
                cd = 5;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic accept(input logic [7:0] a, input logic [7:0] b);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        if (!in_ready) check("in_ready_wait_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] expp, input int stall);
        int k;
        int starts;
        accept(a, b);
        check("load_state", 32'(state_out), 32'd1);
        starts = 0;
        k = 0;
        while (!out_valid && k < 50) begin
            if (mult_start) starts++;
            tick();
            k++;
        end
        exp_cnt = (exp_cnt + 1) & 255;
        check("latency", 32'(k), 32'd6);
        check("start_pulses", 32'(starts), 32'd1);
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_product", 32'(out_product), 32'(expp));
        check("operands_held", 32'({mult_a, mult_b}), 32'({a, b}));
        check("op_cnt", 32'(op_cnt), 32'(exp_cnt));
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_product", 32'(out_product), 32'(expp));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold_exit_state", 32'(state_out), 32'd0);
        check("hold_exit_in_ready", 32'(in_ready), 32'd1);
        check("hold_exit_valid", 32'(out_valid), 32'd0);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int          stall;
        logic [15:0] prod;
    } vec_t;

    vec_t vt[7];

    initial begin
        int k;
        int prev;
        logic [7:0] ra;
        logic [7:0] rb;

        vt[0] = '{a: 8'hFF, b: 8'hFF, stall: 0,  prod: 16'hFE01};
        vt[1] = '{a: 8'h0C, b: 8'h0D, stall: 10, prod: 16'h009C};
        vt[2] = '{a: 8'h00, b: 8'h55, stall: 1,  prod: 16'h0000};
        vt[3] = '{a: 8'h01, b: 8'hFF, stall: 0,  prod: 16'h00FF};
        vt[4] = '{a: 8'h80, b: 8'h02, stall: 2,  prod: 16'h0100};
        vt[5] = '{a: 8'hAA, b: 8'h55, stall: 0,  prod: 16'h3872};
        vt[6] = '{a: 8'h10, b: 8'h10, stall: 3,  prod: 16'h0100};

        // Reset state
        tick();
        tick();
        check("rst_state", 32'(state_out), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_outs", 32'({mult_start, out_valid, err}), 32'd0);
        check("rst_data", 32'({mult_a, mult_b, out_product}), 32'd0);
        check("rst_op_cnt", 32'(op_cnt), 32'd0);
        reset_a = 1'b1;
        tick();

        // err_clr outside ERR does nothing
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr_idle_state", 32'(state_out), 32'd0);
        check("err_clr_idle_err", 32'(err), 32'd0);

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].prod, vt[i].stall);
        end

        // Asynchronous reset in the middle of WAIT
        accept(8'h21, 8'h03);
        tick();
        tick();
        check("pre_reset_wait", 32'(state_out), 32'd2);
        #3;
        reset_a = 1'b0;
        #1;
        check("areset_state", 32'(state_out), 32'd0);
        check("areset_in_ready", 32'(in_ready), 32'd1);
        check("areset_outs", 32'({mult_start, out_valid, err}), 32'd0);
        check("areset_data", 32'({mult_a, mult_b, out_product}), 32'd0);
        check("areset_op_cnt", 32'(op_cnt), 32'd0);
        exp_cnt = 0;
        tick();
        reset_a = 1'b1;
        tick();
        tick();
        check("post_reset_idle", 32'({state_out, out_valid}), 32'd0);

        // Spurious done in IDLE
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        check("spur_idle_state", 32'(state_out), 32'd5);
        check("spur_idle_flags", 32'({err, in_ready, out_valid, mult_start}), 32'b1000);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("err_holds", 32'(state_out), 32'd5);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr_state", 32'(state_out), 32'd0);
        check("err_clr_err", 32'(err), 32'd0);
        check("err_clr_op_cnt", 32'(op_cnt), 32'(exp_cnt));

        // Spurious done in HOLD drops the result
        accept(8'h03, 8'h07);
        k = 0;
        while (!out_valid && k < 50) begin
            tick();
            k++;
        end
        exp_cnt = (exp_cnt + 1) & 255;
        check("spur_hold_product", 32'(out_product), 32'h15);
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        check("spur_hold_valid", 32'(out_valid), 32'd0);
        check("spur_hold_state", 32'(state_out), 32'd5);
        check("spur_hold_op_cnt", 32'(op_cnt), 32'(exp_cnt));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("spur_hold_clr", 32'(state_out), 32'd0);

        // Multiplier that never answers
        mute = 1'b1;
        accept(8'h05, 8'h05);
`ifdef MULT_HOST_TIMEOUT_EN
        k = 0;
        while (state_out != 3'b101 && k < 40) begin
            tick();
            k++;
        end
        check("wdog_cycles", 32'(k), 32'(TO + 1));
        check("wdog_err", 32'(err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("wdog_clr_state", 32'(state_out), 32'd0);
        check("wdog_clr_err", 32'(err), 32'd0);
        check("wdog_op_cnt", 32'(op_cnt), 32'(exp_cnt));
`else
        for (int i = 0; i < 40; i++) tick();
        check("no_wdog_still_wait", 32'(state_out), 32'd2);
        check("no_wdog_err", 32'(err), 32'd0);
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        exp_cnt = (exp_cnt + 1) & 255;
        check("late_done_hold", 32'(out_valid), 32'd1);
        check("late_done_op_cnt", 32'(op_cnt), 32'(exp_cnt));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("late_done_idle", 32'(state_out), 32'd0);
`endif
        mute = 1'b0;

        // Random back-to-back operations through an op_cnt wrap
        for (int n = 0; n < 256; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            prev = int'(op_cnt);
            if ($urandom_range(0, 3) == 0) tick();
            run_op(ra, rb, 16'(ra) * 16'(rb), int'($urandom_range(0, 2)));
            if (prev == 255) check("op_cnt_wrap", 32'(op_cnt), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
